// File: rtl/axi_lite_arbiter_2x1.sv
// axi_lite_arbiter_2x1
// Shares one AXI4-lite slave port between two masters (m0 = PicoRV32,
// m1 = XCrypto co-processor). Read and write channels are arbitrated
// independently, round-robin on contention, one outstanding transaction
// per channel. Once a master is granted, every handshake and response is
// a combinational pass-through; the only added latency is the single
// arbitration cycle spent in IDLE.

module axi_lite_arbiter_2x1 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  // master 0
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [AW-1:0]   m0_awaddr,
  input  logic [2:0]      m0_awprot,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [2:0]      m0_arprot,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [DW-1:0]   m0_rdata,

  // master 1
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [2:0]      m1_awprot,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [2:0]      m1_arprot,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [DW-1:0]   m1_rdata,

  // shared slave
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [AW-1:0]   s_awaddr,
  output logic [2:0]      s_awprot,
  output logic            s_wvalid,
  input  logic            s_wready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  input  logic            s_bvalid,
  output logic            s_bready,
  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [AW-1:0]   s_araddr,
  output logic [2:0]      s_arprot,
  input  logic            s_rvalid,
  output logic            s_rready,
  input  logic [DW-1:0]   s_rdata
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    prot;
  } addr_req_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
  } wr_data_t;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;

  // per-master views, index 0 = m0, index 1 = m1
  logic [1:0]            arvalid, rready, awvalid, wvalid, bready;
  logic [1:0]            arready, rvalid, awready, wready, bvalid;
  addr_req_t [1:0]       ar_req, aw_req;
  wr_data_t  [1:0]       w_req;
  logic [DW-1:0]         rdata_bc;

  assign arvalid = {m1_arvalid, m0_arvalid};
  assign rready  = {m1_rready,  m0_rready};
  assign awvalid = {m1_awvalid, m0_awvalid};
  assign wvalid  = {m1_wvalid,  m0_wvalid};
  assign bready  = {m1_bready,  m0_bready};

  assign ar_req[0] = '{addr: m0_araddr, prot: m0_arprot};
  assign ar_req[1] = '{addr: m1_araddr, prot: m1_arprot};
  assign aw_req[0] = '{addr: m0_awaddr, prot: m0_awprot};
  assign aw_req[1] = '{addr: m1_awaddr, prot: m1_awprot};
  assign w_req[0]  = '{data: m0_wdata,  strb: m0_wstrb};
  assign w_req[1]  = '{data: m1_wdata,  strb: m1_wstrb};

  assign m0_arready = arready[0];
  assign m1_arready = arready[1];
  assign m0_rvalid  = rvalid[0];
  assign m1_rvalid  = rvalid[1];
  assign m0_awready = awready[0];
  assign m1_awready = awready[1];
  assign m0_wready  = wready[0];
  assign m1_wready  = wready[1];
  assign m0_bvalid  = bvalid[0];
  assign m1_bvalid  = bvalid[1];
  // read data is shared by both masters; only the granted one sees rvalid
  assign m0_rdata   = rdata_bc;
  assign m1_rdata   = rdata_bc;

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  rd_state_t rd_state, rd_nxt;
  logic      rd_gnt;   // 0 = m0, 1 = m1
  logic      rd_last;  // master granted most recently
  logic      rd_win;

  // on contention the master not served last time wins
  assign rd_win = (&arvalid) ? ~rd_last : arvalid[1];

  // read state, grant and round-robin history
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rd_state <= RD_IDLE;
      rd_gnt   <= 1'b0;
      rd_last  <= 1'b1;
    end else begin
      rd_state <= rd_nxt;
      if (rd_state == RD_IDLE && |arvalid) begin
        rd_gnt  <= rd_win;
        rd_last <= rd_win;
      end
    end
  end

  // read next-state and slave/master routing for the granted master
  always_comb begin
    rd_nxt    = rd_state;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arprot  = '0;
    s_rready  = 1'b0;
    arready   = '0;
    rvalid    = '0;
    rdata_bc  = '0;
    case (rd_state)
      RD_IDLE: begin
        if (|arvalid) rd_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        s_arvalid       = arvalid[rd_gnt];
        s_araddr        = ar_req[rd_gnt].addr;
        s_arprot        = ar_req[rd_gnt].prot;
        arready[rd_gnt] = s_arready;
        if (arvalid[rd_gnt] && s_arready) rd_nxt = RD_DATA;
      end
      RD_DATA: begin
        s_araddr       = ar_req[rd_gnt].addr;
        s_arprot       = ar_req[rd_gnt].prot;
        s_rready       = rready[rd_gnt];
        rvalid[rd_gnt] = s_rvalid;
        rdata_bc       = s_rdata;
        if (s_rvalid && rready[rd_gnt]) rd_nxt = RD_IDLE;
      end
      default: rd_nxt = RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  wr_state_t wr_state, wr_nxt;
  logic      wr_gnt;
  logic      wr_last;
  logic      wr_win;
  logic [1:0] wr_req;
  logic      aw_done, w_done;   // AW / W already accepted by the slave
  logic      aw_hs, w_hs;

  // a write is requested by either its address or its data arriving first
  assign wr_req = awvalid | wvalid;
  assign wr_win = (&wr_req) ? ~wr_last : wr_req[1];

  // write state, grant, history and per-transaction AW/W completion flags
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_state <= WR_IDLE;
      wr_gnt   <= 1'b0;
      wr_last  <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_nxt;
      if (wr_state == WR_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (|wr_req) begin
          wr_gnt  <= wr_win;
          wr_last <= wr_win;
        end
      end else if (wr_state == WR_ADDR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // write next-state and routing; AW and W may complete in either order
  always_comb begin
    wr_nxt    = wr_state;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awprot  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_bready  = 1'b0;
    awready   = '0;
    wready    = '0;
    bvalid    = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (|wr_req) wr_nxt = WR_ADDR;
      end
      WR_ADDR: begin
        s_awaddr       = aw_req[wr_gnt].addr;
        s_awprot       = aw_req[wr_gnt].prot;
        s_wdata        = w_req[wr_gnt].data;
        s_wstrb        = w_req[wr_gnt].strb;
        s_awvalid      = awvalid[wr_gnt] & ~aw_done;
        s_wvalid       = wvalid[wr_gnt] & ~w_done;
        awready[wr_gnt] = s_awready & ~aw_done;
        wready[wr_gnt]  = s_wready & ~w_done;
        aw_hs          = s_awvalid & s_awready;
        w_hs           = s_wvalid & s_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) wr_nxt = WR_RESP;
      end
      WR_RESP: begin
        s_awaddr       = aw_req[wr_gnt].addr;
        s_awprot       = aw_req[wr_gnt].prot;
        s_wdata        = w_req[wr_gnt].data;
        s_wstrb        = w_req[wr_gnt].strb;
        s_bready       = bready[wr_gnt];
        bvalid[wr_gnt] = s_bvalid;
        if (s_bvalid && bready[wr_gnt]) wr_nxt = WR_IDLE;
      end
      default: wr_nxt = WR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// tb_axi_lite_arbiter_2x1
// Directed bench: the slave is played by the sequence below, masters drop
// valid after their handshake, and a scoreboard of expected slave-side
// addresses/data, read data and B routing is popped as handshakes occur.

module tb_axi_lite_arbiter_2x1;
  localparam int AW = 32;
  localparam int DW = 32;

  logic g_clk, g_resetn;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [AW-1:0] m0_awaddr, m0_araddr;
  logic [2:0] m0_awprot, m0_arprot;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [DW/8-1:0] m0_wstrb;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [AW-1:0] m1_awaddr, m1_araddr;
  logic [2:0] m1_awprot, m1_arprot;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [DW/8-1:0] m1_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [2:0] s_awprot, s_arprot;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;

  axi_lite_arbiter_2x1 #(.AW(AW), .DW(DW)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_exp_ar[$];
  logic [31:0] q_exp_aw[$];
  logic [35:0] q_exp_w[$];   // {strb, data}
  logic [31:0] q_rd0[$];
  logic [31:0] q_rd1[$];
  int          q_b[$];       // master expected to receive each B

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: score handshakes seen this cycle, then apply master/slave
  // valid drops just after the edge
  task automatic step();
    logic h_ar, h_aw, h_w, h_sr, h_sb, h0ar, h1ar, h0aw, h1aw, h0w, h1w;
    #1;
    h_ar = s_arvalid & s_arready;
    h_aw = s_awvalid & s_awready;
    h_w  = s_wvalid & s_wready;
    h_sr = s_rvalid & s_rready;
    h_sb = s_bvalid & s_bready;
    h0ar = m0_arvalid & m0_arready;  h1ar = m1_arvalid & m1_arready;
    h0aw = m0_awvalid & m0_awready;  h1aw = m1_awvalid & m1_awready;
    h0w  = m0_wvalid & m0_wready;    h1w  = m1_wvalid & m1_wready;
    if (h_ar) begin
      if (q_exp_ar.size() == 0) chk("ar_unexpected", q_exp_ar.size(), 1);
      else chk("ar_addr", s_araddr, q_exp_ar.pop_front());
    end
    if (h_aw) begin
      if (q_exp_aw.size() == 0) chk("aw_unexpected", q_exp_aw.size(), 1);
      else chk("aw_addr", s_awaddr, q_exp_aw.pop_front());
    end
    if (h_w) begin
      if (q_exp_w.size() == 0) chk("w_unexpected", q_exp_w.size(), 1);
      else chk("w_data", {s_wstrb, s_wdata}, q_exp_w.pop_front());
    end
    if (m0_rvalid & m0_rready) begin
      if (q_rd0.size() == 0) chk("m0_r_unexpected", q_rd0.size(), 1);
      else chk("m0_rdata", m0_rdata, q_rd0.pop_front());
    end
    if (m1_rvalid & m1_rready) begin
      if (q_rd1.size() == 0) chk("m1_r_unexpected", q_rd1.size(), 1);
      else chk("m1_rdata", m1_rdata, q_rd1.pop_front());
    end
    if (m0_bvalid & m0_bready) begin
      if (q_b.size() == 0) chk("m0_b_unexpected", q_b.size(), 1);
      else chk("b_route_m0", 0, q_b.pop_front());
    end
    if (m1_bvalid & m1_bready) begin
      if (q_b.size() == 0) chk("m1_b_unexpected", q_b.size(), 1);
      else chk("b_route_m1", 1, q_b.pop_front());
    end
    @(posedge g_clk);
    #1;
    if (h0ar) m0_arvalid = 1'b0;
    if (h1ar) m1_arvalid = 1'b0;
    if (h0aw) m0_awvalid = 1'b0;
    if (h1aw) m1_awvalid = 1'b0;
    if (h0w)  m0_wvalid  = 1'b0;
    if (h1w)  m1_wvalid  = 1'b0;
    if (h_sr) s_rvalid   = 1'b0;
    if (h_sb) s_bvalid   = 1'b0;
    #1;
  endtask

  function automatic logic cond(input int c);
    if (c == 0) return s_arvalid;
    return s_awvalid;
  endfunction

  task automatic wait_sig(input string tag, input int c);
    int n = 0;
    while (!cond(c) && n < 50) begin step(); n++; end
    chk(tag, cond(c), 1);
  endtask

  // slave side of one read: accept AR, wait, return data until R handshake
  task automatic serve_read(input logic [31:0] data, input int r_wait);
    int n = 0;
    wait_sig("rd_req_wait", 0);
    s_arready = 1'b1; step(); s_arready = 1'b0;
    repeat (r_wait) step();
    s_rdata = data; s_rvalid = 1'b1;
    while (s_rvalid && n < 50) begin step(); n++; end
    chk("rd_done_wait", s_rvalid, 0);
  endtask

  // slave side of one write with AW and W presented together
  task automatic serve_write();
    int n = 0;
    wait_sig("wr_req_wait", 1);
    s_awready = 1'b1; s_wready = 1'b1; step();
    s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1;
    while (s_bvalid && n < 50) begin step(); n++; end
    chk("wr_done_wait", s_bvalid, 0);
  endtask

  initial begin
    g_resetn = 1'b0;
    {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready} = '0;
    {m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready} = '0;
    {m0_awaddr, m0_araddr, m0_awprot, m0_arprot, m0_wdata, m0_wstrb} = '0;
    {m1_awaddr, m1_araddr, m1_awprot, m1_arprot, m1_wdata, m1_wstrb} = '0;
    {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata} = '0;

    // reset: outputs stay 0 even with traffic pending on every side
    m0_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1; m0_rready = 1'b1;
    s_rvalid = 1'b1; s_bvalid = 1'b1; s_rdata = 32'hFFFF_FFFF;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; m1_bready = 1'b1;
    #2;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid",  s_wvalid, 0);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_awready", m1_awready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m0_rdata",  m0_rdata, 0);
    chk("rst_s_rready",  s_rready, 0);
    chk("rst_s_bready",  s_bready, 0);
    m0_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata} = '0;
    m0_rready = 1'b1; m1_rready = 1'b1; m0_bready = 1'b1; m1_bready = 1'b1;
    @(posedge g_clk); #1; g_resetn = 1'b1; #1;
    step();

    // read contention three times: m0, m1, m0 (then m1's leftover)
    q_exp_ar.push_back(32'h10); q_exp_ar.push_back(32'h20);
    q_exp_ar.push_back(32'h30); q_exp_ar.push_back(32'h40);
    q_rd0.push_back(32'hA0); q_rd1.push_back(32'hA1);
    q_rd0.push_back(32'hA2); q_rd1.push_back(32'hA3);
    m0_araddr = 32'h10; m1_araddr = 32'h20; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    serve_read(32'hA0, 1);
    m0_araddr = 32'h30; m0_arvalid = 1'b1;
    serve_read(32'hA1, 0);
    m1_araddr = 32'h40; m1_arvalid = 1'b1;
    serve_read(32'hA2, 0);
    serve_read(32'hA3, 0);

    // single read with one arbitration cycle and slave latency
    m0_araddr = 32'h100; m0_arprot = 3'b010;
    q_exp_ar.push_back(32'h100); q_rd0.push_back(32'hDEADBEEF);
    m0_arvalid = 1'b1;
    #1 chk("t1_arb_cycle", s_arvalid, 0);
    step();
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_s_arprot", s_arprot, 3'b010);
    chk("t1_m1_arready", m1_arready, 0);
    s_arready = 1'b1; step(); s_arready = 1'b0;
    step(); step();
    s_rdata = 32'hDEADBEEF; s_rvalid = 1'b1;
    #1;
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    chk("t1_rdata_bcast", m1_rdata, 32'hDEADBEEF);
    step();
    chk("t1_idle_araddr", s_araddr, 0);

    // concurrent read (m0) and write (m1)
    m0_araddr = 32'h200; m1_awaddr = 32'h300; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
    q_exp_ar.push_back(32'h200); q_exp_aw.push_back(32'h300);
    q_exp_w.push_back({4'hF, 32'h12345678}); q_rd0.push_back(32'h0200CAFE); q_b.push_back(1);
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    m0_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    step();
    chk("t3_s_arvalid", s_arvalid, 1);
    chk("t3_s_awvalid", s_awvalid, 1);
    chk("t3_s_wvalid",  s_wvalid, 1);
    step();
    s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_rdata = 32'h0200CAFE; s_rvalid = 1'b1; s_bvalid = 1'b1;
    #1;
    chk("t3_m0_rvalid", m0_rvalid, 1);
    chk("t3_m1_bvalid", m1_bvalid, 1);
    chk("t3_m0_bvalid", m0_bvalid, 0);
    step();
    chk("t3_wr_idle_awaddr", s_awaddr, 0);

    // m1 write with W two cycles ahead of AW
    m1_awaddr = 32'h500; m1_wdata = 32'h55AA55AA; m1_wstrb = 4'hA;
    q_exp_aw.push_back(32'h500); q_exp_w.push_back({4'hA, 32'h55AA55AA}); q_b.push_back(1);
    s_awready = 1'b1; s_wready = 1'b1;
    m1_wvalid = 1'b1;
    #1 chk("t4_arb_cycle", s_wvalid, 0);
    step();
    chk("t4_s_wvalid", s_wvalid, 1);
    chk("t4_s_awvalid_early", s_awvalid, 0);
    step();
    m1_awvalid = 1'b1;
    #1;
    chk("t4_s_wvalid_once", s_wvalid, 0);
    chk("t4_wready_after_w", m1_wready, 0);
    chk("t4_s_awvalid", s_awvalid, 1);
    step();
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1;
    #1;
    chk("t4_m1_bvalid", m1_bvalid, 1);
    chk("t4_m0_bvalid", m0_bvalid, 0);
    step();
    step();
    chk("t4_single_b", m1_bvalid, 0);

    // back-pressure on AR then on R
    m0_araddr = 32'h600;
    q_exp_ar.push_back(32'h600); q_rd0.push_back(32'h0BADF00D);
    m0_arvalid = 1'b1;
    step();
    repeat (5) begin
      chk("t5_araddr_hold", s_araddr, 32'h600);
      chk("t5_arready_low", m0_arready, 0);
      step();
    end
    s_arready = 1'b1; step(); s_arready = 1'b0;
    chk("t5_araddr_data", s_araddr, 32'h600);
    m0_rready = 1'b0; s_rdata = 32'h0BADF00D; s_rvalid = 1'b1;
    repeat (2) begin
      #1;
      chk("t5_s_rready_low", s_rready, 0);
      chk("t5_m0_rvalid", m0_rvalid, 1);
      step();
    end
    m0_rready = 1'b1;
    #1 chk("t5_s_rready_high", s_rready, 1);
    step();
    chk("t5_idle_araddr", s_araddr, 0);

    // reset while waiting for B
    m1_awaddr = 32'h700; m1_wdata = 32'h77777777; m1_wstrb = 4'hF;
    q_exp_aw.push_back(32'h700); q_exp_w.push_back({4'hF, 32'h77777777});
    s_awready = 1'b1; s_wready = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    step(); step();
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1;
    #1 chk("t6_bvalid_pre", m1_bvalid, 1);
    g_resetn = 1'b0;
    #1;
    chk("t6_rst_m1_bvalid", m1_bvalid, 0);
    chk("t6_rst_s_bready", s_bready, 0);
    chk("t6_rst_s_awaddr", s_awaddr, 0);
    chk("t6_rst_s_wdata", s_wdata, 0);
    s_bvalid = 1'b0;
    step();
    g_resetn = 1'b1;
    step();
    m1_awaddr = 32'h400; m1_wdata = 32'h40404040; m1_wstrb = 4'hF;
    q_exp_aw.push_back(32'h400); q_exp_w.push_back({4'hF, 32'h40404040}); q_b.push_back(1);
    m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    serve_write();

    // write contention: m0 first, then m1
    m0_awaddr = 32'h800; m0_wdata = 32'h88888888; m0_wstrb = 4'h3;
    m1_awaddr = 32'h900; m1_wdata = 32'h99999999; m1_wstrb = 4'hC;
    q_exp_aw.push_back(32'h800); q_exp_aw.push_back(32'h900);
    q_exp_w.push_back({4'h3, 32'h88888888}); q_exp_w.push_back({4'hC, 32'h99999999});
    q_b.push_back(0); q_b.push_back(1);
    m0_awvalid = 1'b1; m0_wvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    serve_write();
    serve_write();
    step();

    chk("sb_ar_left", q_exp_ar.size(), 0);
    chk("sb_aw_left", q_exp_aw.size(), 0);
    chk("sb_w_left",  q_exp_w.size(), 0);
    chk("sb_rd0_left", q_rd0.size(), 0);
    chk("sb_rd1_left", q_rd1.size(), 0);
    chk("sb_b_left",  q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2x1.md
# axi_lite_arbiter_2x1

Two-master, one-slave AXI4-lite arbiter that shares a single memory port between the PicoRV32 master (m0) and the XCrypto co-processor master (m1). It sits between the `scarv_prv_xcrypt_top` master ports and a shared `axi_sram`, so instruction, data and co-processor traffic all reach one memory image. Read and write channels are arbitrated independently with round-robin fairness and one outstanding transaction per channel.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (write strobe width is DW/8)

Ports (m0 = PicoRV32, m1 = co-processor, s = shared slave):
- g_clk  in  1  clock; all logic on rising edge
- g_resetn  in  1  reset, asynchronous, active-low
- m0_/m1_ awvalid, wvalid, bready, arvalid, rready  in  1  master requests and response-ready
- m0_/m1_ awaddr, araddr  in  AW  master addresses
- m0_/m1_ awprot, arprot  in  3  master protection
- m0_/m1_ wdata  in  DW;  m0_/m1_ wstrb  in  DW/8
- m0_/m1_ awready, wready, arready, bvalid, rvalid  out  1  per-master handshakes
- m0_/m1_ rdata  out  DW  read data
- s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready  out  1  slave-side requests
- s_awaddr, s_araddr  out  AW;  s_awprot, s_arprot  out  3;  s_wdata  out  DW;  s_wstrb  out  DW/8
- s_awready, s_wready, s_arready, s_bvalid, s_rvalid  in  1;  s_rdata  in  DW

## Operation
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA. Write FSM states: WR_IDLE, WR_ADDR, WR_RESP.
- The channels are fully independent: m0 reading while m1 writes is legal and concurrent.
- Arbitration in IDLE: requester is arvalid (read) or awvalid|wvalid (write). Single requester wins. If both request, the winner is the master not granted last on that channel. Registers `rd_last` and `wr_last` both reset to m1, so m0 wins the first contention.
- Grant is registered on leaving IDLE, and `*_last` updates to the winner at the same edge.
- RD_ADDR: s_ar* = granted master's ar*. Granted arready = s_arready. On s_arvalid & s_arready, go to RD_DATA.
- RD_DATA: granted rvalid = s_rvalid; s_rready = granted rready. rdata is broadcast to both masters. On s_rvalid & s_rready, go to RD_IDLE.
- WR_ADDR: flags aw_done and w_done are cleared on entry. s_awvalid = granted awvalid & !aw_done; s_wvalid = granted wvalid & !w_done. Each flag sets on its slave handshake. Go to WR_RESP when both are done; an AW and W handshake in the same cycle counts for both.
- WR_RESP: granted bvalid = s_bvalid; s_bready = granted bready. On handshake, go to WR_IDLE.
- Non-granted master: every ready and valid output is held at 0. Its requests wait and are never dropped.
- Slave address, prot, data and strb outputs are driven to 0 when the owning FSM is in IDLE.

## Timing
- Reset (async assert): both FSMs go to IDLE, grants clear, flags clear, `*_last` = m1. Every output is 0 immediately. Release is synchronous on the next g_clk edge.
- Reset mid-transaction aborts the transaction with no completion to either master.
- Arbitration adds exactly 1 cycle: a request seen in IDLE at cycle N gives slave valid high in cycle N+1.
- After AR/AW/W, all paths are combinational pass-through, with zero added latency for handshakes and responses.
- Return to IDLE takes 1 cycle after the final R or B handshake. Back-to-back transactions from one master therefore have 1 idle cycle between completion and the next grant.
- A master that withdraws valid in IDLE before the grant edge is not granted. Masters are AXI-compliant and do not withdraw after the grant.
- Slave stall (ready=0 for any number of cycles) holds the state and the forwarded signals stable.

## Test plan
- Single read: m0 araddr=0x100, slave returns 0xDEADBEEF after 3 cycles -> s_arvalid rises 1 cycle after m0_arvalid; m0_rvalid carries 0xDEADBEEF; m1_rvalid stays 0.
- Contention: m0 and m1 assert arvalid in the same cycle, 3 times in a row -> grant order m0, m1, m0.
- Concurrent channels: m0 reads 0x200 while m1 writes 0x300=0x12345678, strb=0xF -> both complete with no extra stall; the slave sees the write at 0x300.
- Write with W before AW: m1 wvalid 2 cycles ahead of awvalid, s_wready=1 -> W accepted once (s_wvalid drops after handshake); s_awvalid follows; exactly one B goes to m1.
- Back-pressure: s_arready held 0 for 5 cycles, then s_rvalid with m0_rready=0 for 2 cycles -> s_araddr stays stable; s_rready follows m0_rready; completion occurs only on the mutual handshake.
- Reset mid-write: g_resetn low in WR_RESP -> all outputs 0 asynchronously. After release, a new m1 write of 0x400 completes normally.
